reg_checker: RTL

- Synthesizable end-of-test register checker for processor benches and on-FPGA self-test.
- Holds a table of expected register values and, once started, walks a register range through the processor's debug read port (RegAddr/RegData).
- Compares each register read against its expected value and reports per-register mismatches, an error count and a pass/fail verdict.
- A watchdog flags a run whose start trigger never arrives. Width, register range, read latency and timeout are parametrised.

---
 rtl/reg_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/reg_checker.sv
// End-of-test register checker: walks a register range through a processor debug
// read port and compares each value against a loadable table of expected values.
module reg_checker #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31,
   parameter int READ_LAT  = 1,
   parameter int TIMEOUT   = 10000,
   parameter int CNT_W     = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Clear,
   input  logic              ExpWrEn,
   input  logic [ADDR_W-1:0] ExpWrAddr,
   input  logic [DATA_W-1:0] ExpWrData,
   output logic [ADDR_W-1:0] RegAddr,
   input  logic [DATA_W-1:0] RegData,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic              TimedOut,
   output logic              ErrValid,
   output logic [ADDR_W-1:0] ErrReg,
   output logic [DATA_W-1:0] ErrExp,
   output logic [DATA_W-1:0] ErrAct,
   output logic [CNT_W-1:0]  ErrCount
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CMP,
      S_DONE,
      S_TIMEOUT
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] exp_val [DEPTH];
   logic [DEPTH-1:0]  exp_vld;
   logic [ADDR_W-1:0] ptr;
   logic [LAT_W-1:0]  lat_cnt;
   logic [WD_W-1:0]   wd;

   logic              wr_ok;
   logic [DEPTH-1:0]  vld_eff;
   int                search_from;
   logic              nxt_found;
   logic [ADDR_W-1:0] nxt_idx;
   logic              mismatch;
   logic [CNT_W-1:0]  cnt_inc;
   logic              wd_expire;

   assign wr_ok = ExpWrEn && (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);

   // A write landing in the Start cycle must already be visible to the first search.
   always_comb begin
      vld_eff = exp_vld;
      if (wr_ok) vld_eff[ExpWrAddr] = 1'b1;
   end

   always_comb begin
      search_from = (state == S_IDLE) ? FIRST_REG : int'(ptr) + 1;
      nxt_found   = 1'b0;
      nxt_idx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!nxt_found && i >= search_from && i >= FIRST_REG && i <= LAST_REG && vld_eff[i]) begin
            nxt_found = 1'b1;
            nxt_idx   = ADDR_W'(i);
         end
      end
   end

   assign mismatch  = (RegData != exp_val[ptr]);
   assign cnt_inc   = (ErrCount == CNT_MAX) ? ErrCount : ErrCount + 1'b1;
   assign wd_expire = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT - 1));

   always_ff @(posedge Clock) begin
      if (!Reset && wr_ok) exp_val[ExpWrAddr] <= ExpWrData;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= S_IDLE;
         exp_vld  <= '0;
         ptr      <= '0;
         lat_cnt  <= '0;
         wd       <= '0;
         RegAddr  <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Pass     <= 1'b0;
         TimedOut <= 1'b0;
         ErrValid <= 1'b0;
         ErrReg   <= '0;
         ErrExp   <= '0;
         ErrAct   <= '0;
         ErrCount <= '0;
      end else begin
         ErrValid <= 1'b0;
         if (wr_ok) exp_vld[ExpWrAddr] <= 1'b1;
         case (state)
            S_IDLE: begin
               // Start takes priority over a watchdog expiring in the same cycle.
               if (Start) begin
                  wd       <= '0;
                  ErrCount <= '0;
                  if (nxt_found) begin
                     state   <= S_READ;
                     ptr     <= nxt_idx;
                     RegAddr <= nxt_idx;
                     lat_cnt <= '0;
                     Busy    <= 1'b1;
                  end else begin
                     state <= S_DONE;
                     Done  <= 1'b1;
                     Pass  <= 1'b1;
                  end
               end else if (wd_expire) begin
                  state    <= S_TIMEOUT;
                  Done     <= 1'b1;
                  TimedOut <= 1'b1;
                  Pass     <= 1'b0;
               end else if (TIMEOUT != 0) begin
                  wd <= wd + 1'b1;
               end
            end
            S_READ: begin
               if (lat_cnt == LAT_W'(READ_LAT - 1)) state <= S_CMP;
               else lat_cnt <= lat_cnt + 1'b1;
            end
            S_CMP: begin
               if (mismatch) begin
                  ErrValid <= 1'b1;
                  ErrReg   <= ptr;
                  ErrExp   <= exp_val[ptr];
                  ErrAct   <= RegData;
                  ErrCount <= cnt_inc;
               end
               if (nxt_found) begin
                  state   <= S_READ;
                  ptr     <= nxt_idx;
                  RegAddr <= nxt_idx;
                  lat_cnt <= '0;
               end else begin
                  state <= S_DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
                  Pass  <= !mismatch && (ErrCount == '0);
               end
            end
            S_DONE, S_TIMEOUT: begin
               if (Clear) begin
                  state    <= S_IDLE;
                  Done     <= 1'b0;
                  Pass     <= 1'b0;
                  TimedOut <= 1'b0;
                  ErrCount <= '0;
                  wd       <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
